// File: rtl/fd_pkg.sv
// Shared defaults and helpers for the fd delay-line family.
package fd_pkg;

    localparam int unsigned FD_DEFAULT_WIDTH = 1;
    localparam int unsigned FD_DEFAULT_DEPTH = 1;
    localparam int unsigned FD_DEFAULT_INIT  = 0;

    function automatic int unsigned fd_tap_width(input int unsigned depth,
                                                 input int unsigned width);
        return depth * width;
    endfunction

endpackage

// File: rtl/fd_stage.sv
// One WIDTH-bit register of the fd chain: synchronous reset to INIT, optional
// clock enable when FD_CE_EN is defined.
module fd_stage
    import fd_pkg::*;
#(
    parameter int unsigned       WIDTH = FD_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  INIT  = WIDTH'(FD_DEFAULT_INIT)
) (
    input  logic             C,
    input  logic             R,
`ifdef FD_CE_EN
    input  logic             CE,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Declaration initialiser gives the defined power-up value before any reset.
    logic [WIDTH-1:0] q_q = INIT;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
`ifdef FD_CE_EN
        if (CE) q_d = D;
`else
        q_d = D;
`endif
    end

    always_ff @(posedge C) begin
        if (R) q_q <= INIT;
        else   q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/fd.sv
// DEPTH-stage, WIDTH-bit register chain with tap bus and OR-of-all-bits flag.
// Define FD_CE_EN to add the CE clock-enable port.
module fd
    import fd_pkg::*;
#(
    parameter int unsigned       WIDTH = FD_DEFAULT_WIDTH,
    parameter int unsigned       DEPTH = FD_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0]  INIT  = WIDTH'(FD_DEFAULT_INIT)
) (
    input  logic                                   C,
    input  logic                                   R,
`ifdef FD_CE_EN
    input  logic                                   CE,
`endif
    input  logic [WIDTH-1:0]                       D,
    output logic [WIDTH-1:0]                       Q,
    output logic [fd_tap_width(DEPTH, WIDTH)-1:0]  TAP,
    output logic                                   ANY
);

    logic [DEPTH*WIDTH-1:0] tap_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (k == 0) begin : g_head
            assign stage_d = D;
        end else begin : g_link
            assign stage_d = tap_q[(k-1)*WIDTH +: WIDTH];
        end

        fd_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .C  (C),
            .R  (R),
`ifdef FD_CE_EN
            .CE (CE),
`endif
            .D  (stage_d),
            .Q  (tap_q[k*WIDTH +: WIDTH])
        );
    end

    assign TAP = tap_q;
    assign Q   = tap_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign ANY = |tap_q;

endmodule

// File: tb/tb_fd.sv
// Self-checking bench for fd: vector table, corner-case sequences and a
// randomized run against a history-log reference model.
module tb_fd;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
`ifdef FD_CE_EN
    logic       ce  = 1'b1;
`endif
    logic [7:0] d8  = '0;
    logic       d1  = 1'b0;

    logic [7:0]  u8_q,  u8z_q,  u2_q;
    logic [23:0] u8_tap, u8z_tap;
    logic [15:0] u2_tap;
    logic        u8_any, u8z_any, u2_any;
    logic        u1_q, u1_any, u0_q, u0_any;
    logic [3:0]  u1_tap;
    logic [0:0]  u0_tap;

    int checks = 0;
    int errors = 0;

    // Reference model: log of D values accepted since the last reset.
    // Stage k holds the (k+1)-th most recent accepted value, else INIT.
    logic [7:0] log8[$];
    logic       log1[$];

    always #5 clk = ~clk;

    fd #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) u8 (
        .C(clk), .R(r),
`ifdef FD_CE_EN
        .CE(ce),
`endif
        .D(d8), .Q(u8_q), .TAP(u8_tap), .ANY(u8_any));

    fd #(.WIDTH(8), .DEPTH(3), .INIT(8'h00)) u8z (
        .C(clk), .R(r),
`ifdef FD_CE_EN
        .CE(ce),
`endif
        .D(d8), .Q(u8z_q), .TAP(u8z_tap), .ANY(u8z_any));

    fd #(.WIDTH(8), .DEPTH(2), .INIT(8'h3C)) u2 (
        .C(clk), .R(r),
`ifdef FD_CE_EN
        .CE(ce),
`endif
        .D(d8), .Q(u2_q), .TAP(u2_tap), .ANY(u2_any));

    fd #(.WIDTH(1), .DEPTH(4), .INIT(1'b0)) u1 (
        .C(clk), .R(r),
`ifdef FD_CE_EN
        .CE(ce),
`endif
        .D(d1), .Q(u1_q), .TAP(u1_tap), .ANY(u1_any));

    fd #(.WIDTH(1), .DEPTH(1), .INIT(1'b0)) u0 (
        .C(clk), .R(r),
`ifdef FD_CE_EN
        .CE(ce),
`endif
        .D(d1), .Q(u0_q), .TAP(u0_tap), .ANY(u0_any));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] stage_val(input bit use8, input int k, input logic [7:0] init);
        int n;
        n = use8 ? log8.size() : log1.size();
        if (n > k) return use8 ? log8[n-1-k] : {7'b0, log1[n-1-k]};
        return init;
    endfunction

    task automatic check_inst(input string nm, input bit use8, input int depth, input int width,
                              input logic [7:0] init, input logic [31:0] tap_act,
                              input logic [7:0] q_act, input logic any_act);
        logic [31:0] tap_exp;
        logic [7:0]  s;
        logic [7:0]  q_exp;
        tap_exp = '0;
        for (int k = 0; k < depth; k++) begin
            s = stage_val(use8, k, init);
            for (int b = 0; b < width; b++) tap_exp[k*width+b] = s[b];
        end
        s = stage_val(use8, depth-1, init);
        q_exp = (width == 8) ? s : {7'b0, s[0]};
        chk({nm, ".TAP"}, tap_act, tap_exp);
        chk({nm, ".Q"}, {24'b0, q_act}, {24'b0, q_exp});
        chk({nm, ".ANY"}, {31'b0, any_act}, {31'b0, |tap_exp});
    endtask

    task automatic check_all();
        check_inst("u8",  1'b1, 3, 8, 8'hA5, {8'b0, u8_tap},  u8_q,  u8_any);
        check_inst("u8z", 1'b1, 3, 8, 8'h00, {8'b0, u8z_tap}, u8z_q, u8z_any);
        check_inst("u2",  1'b1, 2, 8, 8'h3C, {16'b0, u2_tap}, u2_q,  u2_any);
        check_inst("u1",  1'b0, 4, 1, 8'h00, {28'b0, u1_tap}, {7'b0, u1_q}, u1_any);
        check_inst("u0",  1'b0, 1, 1, 8'h00, {31'b0, u0_tap}, {7'b0, u0_q}, u0_any);
    endtask

    // One rising edge: update the model from the applied inputs, then sample.
    task automatic tick();
        logic en;
        @(posedge clk);
`ifdef FD_CE_EN
        en = ce;
`else
        en = 1'b1;
`endif
        if (r) begin
            log8.delete();
            log1.delete();
        end else if (en) begin
            log8.push_back(d8);
            log1.push_back(d1);
        end
        #1;
        check_all();
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  d;
        logic [7:0]  q;
        logic [23:0] tap;
        logic        any;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   any_cnt, any_first, any_last, q_cnt, q_at;
        logic exp1;

        tbl[0] = '{1'b1, 8'h00, 8'hA5, 24'hA5A5A5, 1'b1};
        tbl[1] = '{1'b1, 8'h00, 8'hA5, 24'hA5A5A5, 1'b1};
        tbl[2] = '{1'b0, 8'h11, 8'hA5, 24'hA5A511, 1'b1};
        tbl[3] = '{1'b0, 8'h22, 8'hA5, 24'hA51122, 1'b1};
        tbl[4] = '{1'b0, 8'h33, 8'h11, 24'h112233, 1'b1};
        tbl[5] = '{1'b0, 8'h44, 8'h22, 24'h223344, 1'b1};
        tbl[6] = '{1'b0, 8'h55, 8'h33, 24'h334455, 1'b1};

        // Power-up values before any reset
        #1;
        chk("pwr.u8.Q", {24'b0, u8_q}, 32'hA5);
        chk("pwr.u8.TAP", {8'b0, u8_tap}, 32'hA5A5A5);

        for (int i = 0; i < 7; i++) begin
            r  = tbl[i].r;
            d8 = tbl[i].d;
            tick();
            chk($sformatf("vec%0d.Q", i),   {24'b0, u8_q},   {24'b0, tbl[i].q});
            chk($sformatf("vec%0d.TAP", i), {8'b0, u8_tap},  {8'b0, tbl[i].tap});
            chk($sformatf("vec%0d.ANY", i), {31'b0, u8_any}, {31'b0, tbl[i].any});
            if (i == 1) begin
                chk("rst.u8z.Q",   {24'b0, u8z_q},   32'h0);
                chk("rst.u8z.ANY", {31'b0, u8z_any}, 32'h0);
            end
        end

        // Single-cycle pulse through the DEPTH=4, WIDTH=1 chain
        r = 1'b1; d1 = 1'b0; tick();
        r = 1'b0; tick();
        any_cnt = 0; any_first = 0; any_last = 0; q_cnt = 0; q_at = 0;
        for (int i = 1; i <= 10; i++) begin
            d1 = (i == 1);
            tick();
            if (u1_any) begin
                any_cnt++;
                if (any_first == 0) any_first = i;
                any_last = i;
            end
            if (u1_q) begin
                q_cnt++;
                q_at = i;
            end
        end
        chk("pulse.any_cnt",   any_cnt,   4);
        chk("pulse.any_first", any_first, 1);
        chk("pulse.any_last",  any_last,  4);
        chk("pulse.q_cnt",     q_cnt,     1);
        chk("pulse.q_at",      q_at,      4);

`ifdef FD_CE_EN
        // Freeze with CE low, then resume without loss or duplication
        r = 1'b1; tick();
        r = 1'b0; d8 = 8'h5A; tick();
        ce = 1'b0; d8 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ce.hold%0d.TAP", i), {16'b0, u2_tap}, 32'h3C5A);
            chk($sformatf("ce.hold%0d.Q", i),   {24'b0, u2_q},   32'h3C);
        end
        ce = 1'b1; d8 = 8'h00; tick();
        chk("ce.resume.Q", {24'b0, u2_q}, 32'h5A);
        tick();
        chk("ce.nodup.Q", {24'b0, u2_q}, 32'h00);
`endif

        // Reset with data in flight, CE low on the same edge
        r = 1'b0; d8 = 8'hFF; tick(); tick();
        chk("mid.pre.Q", {24'b0, u2_q}, 32'hFF);
        r = 1'b1;
`ifdef FD_CE_EN
        ce = 1'b0;
`endif
        tick();
        chk("mid.u2.Q",    {24'b0, u2_q},    32'h3C);
        chk("mid.u2.ANY",  {31'b0, u2_any},  32'h1);
        chk("mid.u8z.Q",   {24'b0, u8z_q},   32'h00);
        chk("mid.u8z.ANY", {31'b0, u8z_any}, 32'h0);
        chk("mid.u8.TAP",  {8'b0, u8_tap},   32'hA5A5A5);
        r = 1'b0;
`ifdef FD_CE_EN
        ce = 1'b1;
`endif

        // Single-stage primitive: Q(t+1) = D(t)
        for (int i = 0; i < 1000; i++) begin
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            exp1 = d1;
            tick();
            chk("prim.Q", {31'b0, u0_q}, {31'b0, exp1});
        end

        // Randomized reset / enable / data
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 15) == 0);
`ifdef FD_CE_EN
            ce = ($urandom_range(0, 3) != 0);
`endif
            d8 = 8'($urandom);
            d1 = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd.md
# fd

Parameterized D-type flip-flop pipeline: a drop-in generalisation of the single-bit `FD` primitive, extended to a DEPTH-stage, WIDTH-bit register chain. Each stage has a synchronous reset and an optional clock enable. It also provides an OR-reduction "any bit set in the chain" flag. In the GT frame-checker it serves as the channel-bonding-sequence delay chain, where the OR flag masks start-of-packet detection while a bonding sequence is in flight. It is also usable as a general retiming/delay line.

## Interface
- WIDTH, default 1: bits per stage; legal range ≥1.
- DEPTH, default 1: number of register stages; legal range ≥1. DEPTH=1, WIDTH=1, INIT=0 with R tied low is functionally identical to `FD`.
- INIT, default 0: WIDTH-bit value loaded into every stage on reset and at power-up.

Ports:
- C, input, 1 bit: clock; all state changes on the rising edge.
- R, input, 1 bit: synchronous reset, active-high.
- CE, input, 1 bit: clock enable, active-high. Present only when FD_CE_EN is defined.
- D, input, WIDTH bits: data into stage 0.
- Q, output, WIDTH bits: stage DEPTH-1, the final stage.
- TAP, output, DEPTH*WIDTH bits: all stages concatenated; stage k occupies bits [k*WIDTH +: WIDTH].
- ANY, output, 1 bit: OR of every bit of every stage.

## Operation
- Stage 0 loads D; stage k loads stage k-1, for k = 1..DEPTH-1.
- Reset:
  - When R=1 at a rising edge of C, every stage loads INIT.
  - R has priority over CE.
  - D is ignored during reset.
- Clock enable (FD_CE_EN only):
  - When R=0 and CE=0, all stages hold.
  - When R=0 and CE=1, all stages shift.
- Outputs:
  - Q, TAP and ANY are derived purely from registers; there is no combinational path from D, R or CE to any output.
  - ANY is combinational from the stage registers only, with no additional register.
- Reset values:
  - Q = INIT.
  - TAP = INIT replicated DEPTH times.
  - ANY = |INIT.
- Power-up: every stage is initialised to INIT at declaration, so outputs are defined before the first reset.

## Timing
- Latency D→Q is exactly DEPTH enabled clock edges.
- Latency D→TAP stage k is k+1 enabled edges.
- A single-cycle pulse on D (WIDTH=1) holds ANY=1 for exactly DEPTH consecutive enabled cycles. The first of those is the cycle after the capturing edge.
- Reset mid-operation: on the edge where R=1, all in-flight data is discarded.
  - Q reflects INIT from the cycle after that edge.
  - New data on D at the first edge with R=0 reaches Q DEPTH edges later.
- R and CE asserted on the same edge: reset wins.
- CE deasserted mid-stream: the pipeline freezes. No data is lost or duplicated, and shifting resumes when CE returns to 1.

## Configuration
- FD_CE_EN defined:
  - The CE port exists.
  - Stages advance only when CE=1.
- FD_CE_EN undefined:
  - The CE port is absent.
  - Stages advance on every rising edge of C; behaviour matches CE permanently at 1.
- Reset behaviour is identical in both builds.

## Structure
- Shared package fd_pkg:
  - FD_DEFAULT_WIDTH = 1, FD_DEFAULT_DEPTH = 1, FD_DEFAULT_INIT = 0.
  - A helper constant for the TAP width (DEPTH*WIDTH) used by integrators.
- Sub-module fd_stage:
  - One WIDTH-bit register with C, R, optional CE and INIT.
  - Instantiated DEPTH times by a generate loop in fd.
- The ANY reduction lives in the top level.

## Test plan
- Reset: WIDTH=8, DEPTH=3, INIT=8'hA5, drive D=8'h00 and R=1 for 2 cycles → Q=8'hA5, TAP=24'hA5A5A5, ANY=1. Repeat with INIT=0 → ANY=0.
- Latency: WIDTH=8, DEPTH=3, R=0, CE=1, drive D=8'h11, 8'h22, 8'h33 on consecutive edges → Q shows 8'h11, 8'h22, 8'h33 on the 3rd, 4th and 5th edges.
- Pulse/ANY: WIDTH=1, DEPTH=4, INIT=0, one-cycle D=1 pulse → ANY=1 for exactly 4 cycles. Q=1 for exactly 1 cycle, 4 edges after capture.
- Clock enable (FD_CE_EN): DEPTH=2, load 8'h5A, drop CE for 3 cycles → Q and TAP frozen. Raise CE → 8'h5A exits Q with no duplication.
- Reset mid-stream plus CE=0: with 8'hFF in flight, assert R=1 and CE=0 on one edge → next cycle Q=INIT, ANY=|INIT.
- Primitive equivalence: WIDTH=1, DEPTH=1, R=0, random D for 1000 cycles → Q(t+1)=D(t).
